// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, sequencer state encoding and default sizing for the
// pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_XORI = 6'b001110;

  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } seq_state_t;

  localparam int MDU_LAT_DEF = 4;
  localparam int PERF_W_DEF  = 16;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds the instruction in ID.
// Instructions that only write rt (lw, xori) do not read it as a source.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [5:0] id_op,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;
  logic rt_is_source;

  assign rs_hit       = (ex_rt == id_rs);
  assign rt_hit       = (ex_rt == id_rt);
  assign rt_is_source = (id_op != OP_LW) && (id_op != OP_XORI);
  assign load_use     = ex_mem_read && (rs_hit || (rt_hit && rt_is_source));

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Merges load-use, taken-branch, MDU occupancy and fetch-miss events into
// per-stage write enables and flushes, and counts PC-stall cycles.
module pipe_hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = 3,
  parameter int PERF_W  = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [5:0]        id_op,
  input  logic              id_is_mdu,
  input  logic              ex_branch_taken,
  input  logic              imem_ready,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  seq_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PERF_W-1:0] stall_reg;
  logic              load_use;
  logic              mdu_enter;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_op       (id_op),
    .load_use    (load_use)
  );

  // A fetch miss does not block MDU entry; only a branch or load-use does.
  assign mdu_enter = id_is_mdu && !ex_branch_taken && !load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (mdu_enter) begin
          state_next = MDU;
          cnt_next   = CNT_W'(MDU_LAT - 1);
        end
      end
      MDU: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_busy    = 1'b0;
    if (!rst) begin
      case (state_reg)
        RUN: begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          idex_we = 1'b1;
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        MDU: begin
          // EX is owned by the MDU; hold upstream and bubble downstream.
          exmem_flush = 1'b1;
          mdu_busy    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (!pc_we && (stall_reg != {PERF_W{1'b1}})) begin
      stall_reg <= stall_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and randomized traffic against a rule-level reference model.
module tb_pipe_hazard_sequencer;
  import pipe_ctrl_pkg::*;

  localparam int MDU_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_read;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic [5:0]  id_op;
  logic        id_is_mdu, ex_branch_taken, imem_ready;
  logic        pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_flush, mdu_busy;
  logic [15:0] stall_cycles;
  logic [6:0]  dut_out;

  int checks = 0;
  int errors = 0;
  int m_hold;
  int m_stall;

  pipe_hazard_sequencer #(.MDU_LAT(MDU_LAT), .CNT_W(3), .PERF_W(16)) dut (
    .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op), .id_is_mdu(id_is_mdu),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .mdu_busy(mdu_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // {pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_flush, mdu_busy}
  assign dut_out = {pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_flush, mdu_busy};

  typedef struct {
    logic       mr;
    logic [4:0] ert, irs, irt;
    logic [5:0] op;
    logic       mdu, br, imr;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic model_lu();
    return ex_mem_read && ((ex_rt == id_rs) ||
           ((ex_rt == id_rt) && (id_op != 6'b100011) && (id_op != 6'b001110)));
  endfunction

  function automatic logic [6:0] model_out();
    if (m_hold > 0)          return 7'b0000011;
    if (ex_branch_taken)     return 7'b1111100;
    if (model_lu())          return 7'b0010100;
    if (!imem_ready)         return 7'b0111000;
    return 7'b1110000;
  endfunction

  task automatic model_edge();
    logic [6:0] o;
    o = model_out();
    if (!o[6] && m_stall < 65535) m_stall++;
    if (m_hold > 0) m_hold--;
    else if (id_is_mdu && !ex_branch_taken && !model_lu()) m_hold = MDU_LAT - 1;
  endtask

  task automatic set_in(logic mr, logic [4:0] ert, logic [4:0] irs, logic [4:0] irt,
                        logic [5:0] op, logic mdu, logic br, logic imr);
    ex_mem_read = mr; ex_rt = ert; id_rs = irs; id_rt = irt; id_op = op;
    id_is_mdu = mdu; ex_branch_taken = br; imem_ready = imr;
  endtask

  // Called at posedge+1; checks mid-cycle, then advances the model on the edge.
  task automatic step(string name);
    #3;
    chk({name, "_out"}, 32'(dut_out), 32'(model_out()));
    chk({name, "_stall"}, 32'(stall_cycles), 32'(m_stall));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 6'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_out", 32'(dut_out), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_hold = 0;
    m_stall = 0;
  endtask

  initial begin
    int s0;
    vecs[0] = '{1'b1, 5'd5, 5'd5, 5'd0, 6'd0,    1'b0, 1'b0, 1'b1, 7'b0010100};
    vecs[1] = '{1'b1, 5'd7, 5'd3, 5'd7, OP_LW,   1'b0, 1'b0, 1'b1, 7'b1110000};
    vecs[2] = '{1'b1, 5'd7, 5'd3, 5'd7, 6'd0,    1'b0, 1'b0, 1'b1, 7'b0010100};
    vecs[3] = '{1'b1, 5'd7, 5'd3, 5'd7, OP_XORI, 1'b0, 1'b0, 1'b1, 7'b1110000};
    vecs[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 6'd0,    1'b0, 1'b0, 1'b1, 7'b1110000};
    vecs[5] = '{1'b1, 5'd5, 5'd5, 5'd0, 6'd0,    1'b1, 1'b1, 1'b1, 7'b1111100};
    vecs[6] = '{1'b0, 5'd1, 5'd2, 5'd3, 6'd0,    1'b0, 1'b0, 1'b0, 7'b0111000};
    vecs[7] = '{1'b1, 5'd9, 5'd9, 5'd0, 6'd0,    1'b0, 1'b0, 1'b0, 7'b0010100};
    vecs[8] = '{1'b0, 5'd1, 5'd2, 5'd3, 6'd0,    1'b0, 1'b1, 1'b0, 7'b1111100};
    vecs[9] = '{1'b0, 5'd1, 5'd2, 5'd3, 6'd0,    1'b0, 1'b0, 1'b1, 7'b1110000};

    do_reset();

    // Directed table; vecs[5] (branch + mdu) must not enter MDU, so vecs[6] sees RUN.
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].mr, vecs[i].ert, vecs[i].irs, vecs[i].irt, vecs[i].op,
             vecs[i].mdu, vecs[i].br, vecs[i].imr);
      #3;
      chk($sformatf("vec%0d", i), 32'(dut_out), 32'(vecs[i].exp));
      @(posedge clk);
      model_edge();
      #1;
      if (i == 0) chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    end

    // MDU occupancy with branch / fetch-miss noise during the hold.
    do_reset();
    s0 = m_stall;
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b1, 1'b0, 1'b1); step("mdu_enter");
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 1'b1, 1'b1); step("mdu_hold1");
    set_in(1'b1, 5'd2, 5'd2, 5'd3, 6'd0, 1'b0, 1'b0, 1'b0); step("mdu_hold2");
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b1, 1'b1, 1'b0); step("mdu_hold3");
    chk("mdu_stall_delta", 32'(stall_cycles), 32'(s0 + 3));
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b1, 1'b0, 1'b1); step("mdu_done_b2b");
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 1'b0, 1'b1); step("b2b_hold1");
    step("b2b_hold2");
    step("b2b_hold3");
    step("b2b_done");

    // Fetch miss for two cycles, then a miss that coincides with MDU entry.
    do_reset();
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 1'b0, 1'b0); step("miss1");
    step("miss2");
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b1, 1'b0, 1'b0); step("miss_mdu");
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 1'b0, 1'b1);
    #3;
    chk("miss_mdu_busy", 32'(mdu_busy), 32'd1);
    @(posedge clk); model_edge(); #1;

    // Asynchronous reset in the middle of the second hold cycle.
    do_reset();
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b1, 1'b0, 1'b1); step("ar_enter");
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 1'b0, 1'b1); step("ar_hold1");
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out", 32'(dut_out), 32'd0);
    chk("ar_stall", 32'(stall_cycles), 32'd0);
    m_hold = 0;
    m_stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("ar_run");

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 3))
        0: op = OP_LW;
        1: op = OP_XORI;
        2: op = 6'd0;
        default: op = 6'($urandom);
      endcase
      set_in(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), op, ($urandom_range(0, 9) < 2),
             ($urandom_range(0, 19) < 3), ($urandom_range(0, 9) < 8));
      step($sformatf("rnd%0d", i));
    end

    // Saturation of the stall counter under a permanent load-use.
    do_reset();
    set_in(1'b1, 5'd4, 5'd4, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    chk("stall_sat", 32'(stall_cycles), 32'h0000FFFF);
    step("sat_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
